// File: rtl/element_retire_tracker_if.sv
// Lane-group stream: one group of NUM_LANES elements tagged with the element offset of lane 0.
// On the writeback side the mask field carries the per-lane write enables.
interface element_retire_tracker_if #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DATA_W    = 32
);
  logic                        valid;
  logic                        ready;
  logic [31:0]                 offset;
  logic [NUM_LANES*DATA_W-1:0] data;
  logic [NUM_LANES-1:0]        mask;

  modport master (output valid, offset, data, mask, input ready);
  modport slave  (input valid, offset, data, mask, output ready);
endinterface

// File: rtl/element_retire_tracker.sv
// Element retire tracker: buffers offset-tagged lane groups in a small FIFO, drains them to the
// VRF writeback port with per-lane write enables, and counts retired elements against vl.
module element_retire_tracker #(
  parameter int unsigned NUM_LANES = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                             CLK,
  input  logic                             RST,
  input  logic                             start,
  input  logic                             clear,
  input  logic [31:0]                      vl,
  input  logic [31:0]                      vstart,
  element_retire_tracker_if.slave          in_if,
  element_retire_tracker_if.master         wb_if,
  output logic [31:0]                      retired_count,
  output logic                             all_retired,
  output logic                             busy,
  output logic                             err_order
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;
  localparam int unsigned GrpW  = NUM_LANES * DATA_W;
  localparam logic [31:0] Lanes32 = 32'(NUM_LANES);
  localparam logic [32:0] Lanes33 = 33'(NUM_LANES);

  typedef enum logic [1:0] {StIdle, StActive, StDrain, StDone} state_e;

  state_e      state_q;
  logic [31:0] vl_q;
  logic [31:0] exp_off_q;
  logic [31:0] retired_q;
  logic        err_q;

  // FIFO storage and pointers; the extra pointer bit distinguishes full from empty.
  logic [31:0]          off_mem  [DEPTH];
  logic [GrpW-1:0]      data_mem [DEPTH];
  logic [NUM_LANES-1:0] wen_mem  [DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [PtrW-1:0]      fill;
  logic [AddrW-1:0]     wr_addr, rd_addr;

  logic                 empty, full, push, pop, drain_empty;
  logic [NUM_LANES-1:0] in_wen;
  logic [31:0]          retire_cnt;

  assign wr_addr = wr_ptr_q[AddrW-1:0];
  assign rd_addr = rd_ptr_q[AddrW-1:0];
  assign fill    = wr_ptr_q - rd_ptr_q;
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_addr == rd_addr) && (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);

  assign in_if.ready = (state_q == StActive) && !full;
  assign push        = in_if.valid && in_if.ready;
  assign pop         = wb_if.valid && wb_if.ready;
  // FIFO will be empty after this edge, counting a pop of the last entry in this cycle.
  assign drain_empty = empty || ((fill == PtrW'(1)) && pop);

  // Head is forced to zero while empty so outputs are defined after reset and flush.
  assign wb_if.valid  = !empty;
  assign wb_if.offset = empty ? '0 : off_mem[rd_addr];
  assign wb_if.data   = empty ? '0 : data_mem[rd_addr];
  assign wb_if.mask   = empty ? '0 : wen_mem[rd_addr];

  assign retired_count = retired_q;
  assign err_order     = err_q;
  assign all_retired   = (state_q == StDone);
  assign busy          = (state_q == StActive) || (state_q == StDrain);

  // Write enables at push: lane active and within vl (33-bit compare, no wrap).
  always_comb begin
    in_wen = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      in_wen[i] = in_if.mask[i] && (({1'b0, in_if.offset} + 33'(i)) < {1'b0, vl_q});
    end
  end

  // Elements retired by the head group: every lane below vl, masked or not.
  always_comb begin
    retire_cnt = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      if (({1'b0, wb_if.offset} + 33'(i)) < {1'b0, vl_q}) begin
        retire_cnt = retire_cnt + 32'd1;
      end
    end
  end

  // FIFO payload write; contents need no reset since the head is gated by empty.
  always_ff @(posedge CLK) begin
    if (push) begin
      off_mem[wr_addr]  <= in_if.offset;
      data_mem[wr_addr] <= in_if.data;
      wen_mem[wr_addr]  <= in_wen;
    end
  end

  // FIFO pointers: flushed by reset or clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Control FSM plus instruction tracking registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      vl_q      <= '0;
      exp_off_q <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else if (clear) begin
      state_q   <= StIdle;
      vl_q      <= '0;
      exp_off_q <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (pop) retired_q <= retired_q + retire_cnt;
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            vl_q      <= vl;
            exp_off_q <= vstart;
            retired_q <= vstart;
            err_q     <= 1'b0;
            state_q   <= ((vl == '0) || (vstart >= vl)) ? StDone : StActive;
          end
        end
        StActive: begin
          if (push) begin
            exp_off_q <= exp_off_q + Lanes32;
            // Out-of-order group is flagged but still written back.
            if (in_if.offset != exp_off_q) err_q <= 1'b1;
            if (({1'b0, exp_off_q} + Lanes33) >= {1'b0, vl_q}) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_empty) state_q <= StDone;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_element_retire_tracker.sv
// Scoreboard bench for element_retire_tracker: the driver queues each expected writeback group,
// a negedge monitor pops and compares on every writeback handshake.
module tb_element_retire_tracker;

  typedef struct {
    logic [31:0] off;
    logic [63:0] data;
    logic [1:0]  wen;
  } grp_t;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start, clear;
  logic [31:0] vl, vstart;
  logic [31:0] retired_count;
  logic        all_retired, busy, err_order;

  int checks   = 0;
  int failures = 0;
  grp_t sb[$];

  element_retire_tracker_if #(.NUM_LANES(2), .DATA_W(32)) in_if ();
  element_retire_tracker_if #(.NUM_LANES(2), .DATA_W(32)) wb_if ();

  element_retire_tracker #(.NUM_LANES(2), .DEPTH(4), .DATA_W(32)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .start         (start),
    .clear         (clear),
    .vl            (vl),
    .vstart        (vstart),
    .in_if         (in_if),
    .wb_if         (wb_if),
    .retired_count (retired_count),
    .all_retired   (all_retired),
    .busy          (busy),
    .err_order     (err_order)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every writeback handshake must match the oldest queued group.
  always @(negedge CLK) begin
    if (!RST && wb_if.valid && wb_if.ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL wb_unexpected actual off=%0d data=0x%0h wen=%b required=none",
                 wb_if.offset, wb_if.data, wb_if.mask);
      end else begin
        grp_t e;
        e = sb.pop_front();
        if (wb_if.offset !== e.off || wb_if.data !== e.data || wb_if.mask !== e.wen) begin
          failures++;
          $display("FAIL wb_group actual off=%0d data=0x%0h wen=%b required off=%0d data=0x%0h wen=%b",
                   wb_if.offset, wb_if.data, wb_if.mask, e.off, e.data, e.wen);
        end
      end
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start(input logic [31:0] l, input logic [31:0] vs);
    vl = l; vstart = vs; start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Drive one group until accepted (bounded); optionally queue its expected writeback.
  task automatic send(input logic [31:0] off, input logic [1:0] mask, input logic [1:0] wen,
                      input bit track);
    int n;
    grp_t g;
    g.off  = off;
    g.data = {32'hB000_0000 + off, 32'hA000_0000 + off};
    g.wen  = wen;
    in_if.valid = 1'b1; in_if.offset = off; in_if.data = g.data; in_if.mask = mask;
    n = 0;
    @(negedge CLK);
    while (!in_if.ready && n < 200) begin
      n++;
      @(negedge CLK);
    end
    if (!in_if.ready) begin
      checks++; failures++;
      $display("FAIL send_timeout actual in_ready=0 required in_ready=1 off=%0d", off);
      in_if.valid = 1'b0;
      return;
    end
    if (track) sb.push_back(g);
    cycle();
    in_if.valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!all_retired && n < 200) begin
      n++;
      cycle();
    end
    chk(name, 64'(all_retired), 64'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wb_valid"}, 64'(wb_if.valid), 64'd0);
    chk({tag, "_wb_offset"}, 64'(wb_if.offset), 64'd0);
    chk({tag, "_wb_data"}, wb_if.data, 64'd0);
    chk({tag, "_wb_wen"}, 64'(wb_if.mask), 64'd0);
    chk({tag, "_in_ready"}, 64'(in_if.ready), 64'd0);
    chk({tag, "_status"}, {28'd0, retired_count, all_retired, busy, err_order}, 64'd0);
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; clear = 1'b0; vl = '0; vstart = '0;
    in_if.valid = 1'b0; in_if.offset = '0; in_if.data = '0; in_if.mask = '0;
    wb_if.ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    RST = 1'b0;
    cycle();

    // 1: vl=6 in order, full masks
    wb_if.ready = 1'b1;
    do_start(32'd6, 32'd0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_retired_start", 64'(retired_count), 64'd0);
    send(32'd0, 2'b11, 2'b11, 1'b1);
    send(32'd2, 2'b11, 2'b11, 1'b1);
    send(32'd4, 2'b11, 2'b11, 1'b1);
    wait_done("t1_done");
    chk("t1_retired", 64'(retired_count), 64'd6);
    chk("t1_err", 64'(err_order), 64'd0);

    // 2: vl=5, tail lane of last group disabled, DRAIN on offset-4 accept
    do_start(32'd5, 32'd0);
    send(32'd0, 2'b11, 2'b11, 1'b1);
    send(32'd2, 2'b11, 2'b11, 1'b1);
    chk("t2_ready_before_last", 64'(in_if.ready), 64'd1);
    send(32'd4, 2'b11, 2'b01, 1'b1);
    chk("t2_drain_ready", 64'(in_if.ready), 64'd0);
    chk("t2_drain_busy", 64'(busy), 64'd1);
    wait_done("t2_done");
    chk("t2_retired", 64'(retired_count), 64'd5);

    // 3: vl=20, backpressure fills the FIFO after exactly four accepts
    wb_if.ready = 1'b0;
    do_start(32'd20, 32'd0);
    send(32'd0, 2'b11, 2'b11, 1'b1);
    send(32'd2, 2'b10, 2'b10, 1'b1);
    send(32'd4, 2'b01, 2'b01, 1'b1);
    send(32'd6, 2'b00, 2'b00, 1'b1);
    in_if.valid = 1'b1; in_if.offset = 32'd8;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("t3_full_ready", 64'(in_if.ready), 64'd0);
    end
    chk("t3_full_wb_valid", 64'(wb_if.valid), 64'd1);
    chk("t3_head_offset", 64'(wb_if.offset), 64'd0);
    cycle();
    wb_if.ready = 1'b1;
    for (int k = 4; k < 10; k++) begin
      send(32'(2 * k), 2'b11, 2'b11, 1'b1);
    end
    wait_done("t3_done");
    chk("t3_retired", 64'(retired_count), 64'd20);

    // 4: vl=8, vstart=4; offset 2 sent where 4 expected
    do_start(32'd8, 32'd4);
    chk("t4_retired_start", 64'(retired_count), 64'd4);
    chk("t4_err_clear", 64'(err_order), 64'd0);
    send(32'd2, 2'b11, 2'b11, 1'b1);
    chk("t4_err_set", 64'(err_order), 64'd1);
    send(32'd6, 2'b11, 2'b11, 1'b1);
    wait_done("t4_done");
    chk("t4_err_sticky", 64'(err_order), 64'd1);
    chk("t4_retired", 64'(retired_count), 64'd8);

    // 5: empty instructions complete immediately
    do_start(32'd0, 32'd0);
    chk("t5a_done", {62'd0, all_retired, busy}, 64'd2);
    chk("t5a_wb_valid", 64'(wb_if.valid), 64'd0);
    do_start(32'd8, 32'd8);
    chk("t5b_done", {62'd0, all_retired, busy}, 64'd2);
    chk("t5b_retired", 64'(retired_count), 64'd8);
    chk("t5b_err", 64'(err_order), 64'd0);

    // 6: clear with buffered groups, start+clear, reset mid-DRAIN
    wb_if.ready = 1'b0;
    do_start(32'd20, 32'd2);
    send(32'd2, 2'b11, 2'b11, 1'b0);
    send(32'd4, 2'b11, 2'b11, 1'b0);
    send(32'd6, 2'b11, 2'b11, 1'b0);
    chk("t6_buffered", 64'(wb_if.valid), 64'd1);
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    chk("t6_clear_wb_valid", 64'(wb_if.valid), 64'd0);
    chk("t6_clear_retired", 64'(retired_count), 64'd0);
    chk("t6_clear_state", {62'd0, all_retired, busy}, 64'd0);
    clear = 1'b1;
    do_start(32'd6, 32'd0);
    clear = 1'b0;
    chk("t6_start_clear", {62'd0, all_retired, busy}, 64'd0);
    do_start(32'd4, 32'd0);
    send(32'd0, 2'b11, 2'b11, 1'b0);
    send(32'd2, 2'b11, 2'b11, 1'b0);
    chk("t6_drain_busy", 64'(busy), 64'd1);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk_zero("t6_rst");
    cycle();
    RST = 1'b0;
    cycle();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
